// File: rtl/way_fill_demux.sv
// Assembles a cache line from narrow fill beats and writes it into one way
// with a single-cycle one-hot strobe; out-of-range ways are dropped with an error pulse.
//
// state   | meaning
// IDLE    | waiting for beat 0, which also carries the destination way
// COLLECT | gathering beats 1..beats-1
// WRITE   | one-cycle strobe of the assembled line to the selected way
module way_fill_demux #(
  parameter int lineSize  = 512,
  parameter int ways      = 8,
  parameter int beatWidth = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     fillValid,
  output logic                     fillReady,
  input  logic [$clog2(ways)-1:0]  fillWay,
  input  logic [beatWidth-1:0]     fillData,
  input  logic                     abort,
  output logic [ways-1:0]          wayWrEn,
  output logic [lineSize-1:0]      wayWrData,
  output logic                     busy,
  output logic                     wayError
);

  localparam int BEATS = lineSize / beatWidth;
  localparam int WAY_W = $clog2(ways);
  localparam int CNT_W = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [WAY_W-1:0]   r_way;
  logic [lineSize-1:0] r_line;
  logic [ways-1:0]    r_wr_en;
  logic               r_error;

  logic               w_accept;
  logic               w_last;
  logic [WAY_W-1:0]   w_way_sel;
  logic               w_way_ok;
  logic [ways-1:0]    w_onehot;

  // Beat 0 arrives in IDLE, so its way has not been latched yet.
  assign w_way_sel = (r_state == IDLE) ? fillWay : r_way;
  assign w_way_ok  = {1'b0, w_way_sel} < (WAY_W+1)'(ways);
  assign w_onehot  = {{(ways-1){1'b0}}, 1'b1} << w_way_sel;
  assign w_last    = (r_beat_cnt == CNT_W'(BEATS - 1));

  always_comb begin
    w_next    = r_state;
    fillReady = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        fillReady = !abort;
      end
      COLLECT: begin
        fillReady = !abort;
        busy      = 1'b1;
        if (abort) w_next = IDLE;
      end
      WRITE: begin
        busy   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    w_accept = fillValid & fillReady;
    if (w_accept) w_next = w_last ? WRITE : COLLECT;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_way      <= '0;
      r_line     <= '0;
      r_wr_en    <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == IDLE)  r_beat_cnt <= '0;
      else if (w_accept)   r_beat_cnt <= r_beat_cnt + 1'b1;
      if (w_accept && r_state == IDLE) r_way <= fillWay;
      for (int k = 0; k < BEATS; k++) begin
        if (w_accept && r_beat_cnt == CNT_W'(k))
          r_line[k*beatWidth +: beatWidth] <= fillData;
      end
      r_wr_en <= (w_accept && w_last && w_way_ok) ? w_onehot : '0;
      r_error <= w_accept && w_last && !w_way_ok;
    end
  end

  assign wayWrEn   = r_wr_en;
  assign wayError  = r_error;
  assign wayWrData = r_line;

endmodule

// File: tb/tb_way_fill_demux.sv
// Directed bench for way_fill_demux: an 8-way and a 6-way instance share the
// same fill stimulus so out-of-range ways can be exercised on the smaller one.
module tb_way_fill_demux;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         fillValid = 1'b0;
  logic [2:0]   fillWay = '0;
  logic [63:0]  fillData = '0;
  logic         abort = 1'b0;

  logic         fillReady, busy, wayError;
  logic [7:0]   wayWrEn;
  logic [511:0] wayWrData;
  logic         fillReady6, busy6, wayError6;
  logic [5:0]   wayWrEn6;
  logic [511:0] wayWrData6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  way_fill_demux #(.lineSize(512), .ways(8), .beatWidth(64)) u_dut (
    .clock(clock), .reset_n(reset_n), .fillValid(fillValid), .fillReady(fillReady),
    .fillWay(fillWay), .fillData(fillData), .abort(abort), .wayWrEn(wayWrEn),
    .wayWrData(wayWrData), .busy(busy), .wayError(wayError)
  );

  way_fill_demux #(.lineSize(512), .ways(6), .beatWidth(64)) u_dut6 (
    .clock(clock), .reset_n(reset_n), .fillValid(fillValid), .fillReady(fillReady6),
    .fillWay(fillWay), .fillData(fillData), .abort(abort), .wayWrEn(wayWrEn6),
    .wayWrData(wayWrData6), .busy(busy6), .wayError(wayError6)
  );

  typedef struct {
    logic [2:0]  way0;
    logic [2:0]  wayk;
    int          stall_at;
    int          stall_len;
    logic        abort_wr;
    logic [63:0] mult;
    logic [7:0]  exp_en;
    logic [5:0]  exp_en6;
    logic        exp_err6;
  } vec_t;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_line(input vec_t v);
    logic [511:0] exp_line;
    for (int k = 0; k < 8; k++) begin
      exp_line[k*64 +: 64] = v.mult * 64'(k);
      if (k == v.stall_at) begin
        fillValid = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          @(negedge clock);
          chk("stall_busy", busy, 1'b1);
          chk("stall_en", wayWrEn, 8'h00);
        end
      end
      fillValid = 1'b1;
      fillWay   = (k == 0) ? v.way0 : v.wayk;
      fillData  = v.mult * 64'(k);
      #1 chk("beat_ready", fillReady, 1'b1);
      @(negedge clock);
      if (k < 7) begin
        chk("collect_en", {wayWrEn6, wayWrEn}, 14'h0);
        chk("collect_err", {wayError6, wayError}, 2'b00);
      end
    end
    fillValid = 1'b0;
    abort     = v.abort_wr;
    #1;
    chk("write_en", wayWrEn, v.exp_en);
    chk("write_en6", wayWrEn6, v.exp_en6);
    chk("write_err6", wayError6, v.exp_err6);
    chk("write_err", wayError, 1'b0);
    chk("write_ready", fillReady, 1'b0);
    chk("write_busy", busy, 1'b1);
    chk("write_data", wayWrData, exp_line);
    chk("write_data6", wayWrData6, exp_line);
    @(negedge clock);
    abort = 1'b0;
    #1;
    chk("after_en", {wayWrEn6, wayWrEn}, 14'h0);
    chk("after_err", {wayError6, wayError}, 2'b00);
    chk("after_ready", fillReady, 1'b1);
    chk("after_busy", busy, 1'b0);
    chk("after_hold", wayWrData, exp_line);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{3'd5, 3'd5, -1, 0, 1'b0, 64'h1111_1111_1111_1111, 8'h20, 6'h20, 1'b0};
    vecs[1] = '{3'd2, 3'd6, -1, 0, 1'b0, 64'h0123_4567_89ab_cdef, 8'h04, 6'h04, 1'b0};
    vecs[2] = '{3'd5, 3'd5,  4, 3, 1'b0, 64'h1111_1111_1111_1111, 8'h20, 6'h20, 1'b0};
    vecs[3] = '{3'd7, 3'd7, -1, 0, 1'b0, 64'ha5a5_a5a5_a5a5_a5a5, 8'h80, 6'h00, 1'b1};
    vecs[4] = '{3'd0, 3'd7, -1, 0, 1'b0, 64'h0f0f_0f0f_0f0f_0f0f, 8'h01, 6'h01, 1'b0};
    vecs[5] = '{3'd4, 3'd1,  2, 1, 1'b1, 64'h3c3c_0000_ffff_0001, 8'h10, 6'h10, 1'b0};

    // Reset held with a beat on offer: nothing must be taken.
    fillValid = 1'b1;
    fillWay   = 3'd3;
    fillData  = 64'hdead_beef_dead_beef;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_en", wayWrEn, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", fillReady, 1'b1);
      chk("rst_err", wayError, 1'b0);
      chk("rst_data", wayWrData, 512'h0);
    end
    fillValid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clock);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", fillReady, 1'b1);

    for (int i = 0; i < 6; i++) begin
      send_line(vecs[i]);
      if (i == 0) begin
        chk("line0_lo", wayWrData[63:0], 64'h0);
        chk("line0_hi", wayWrData[511:448], 64'h7777_7777_7777_7777);
      end
    end

    // Abort after four beats, with a beat presented in the same cycle.
    for (int k = 0; k < 4; k++) begin
      fillValid = 1'b1;
      fillWay   = 3'd1;
      fillData  = 64'hbad0_0000_0000_0000 + 64'(k);
      @(negedge clock);
    end
    abort    = 1'b1;
    fillData = 64'hffff_ffff_ffff_ffff;
    #1;
    chk("abort_ready", fillReady, 1'b0);
    chk("abort_busy_pre", busy, 1'b1);
    @(negedge clock);
    abort     = 1'b0;
    fillValid = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready_post", fillReady, 1'b1);
    chk("abort_en", wayWrEn, 8'h00);
    @(negedge clock);
    chk("abort_no_write", wayWrEn, 8'h00);
    send_line('{3'd3, 3'd3, -1, 0, 1'b0, 64'h0101_0101_0101_0101, 8'h08, 6'h08, 1'b0});

    // Reset asserted during the write cycle kills the strobe immediately.
    for (int k = 0; k < 8; k++) begin
      fillValid = 1'b1;
      fillWay   = 3'd6;
      fillData  = 64'h5555_0000_0000_0000 + 64'(k);
      @(negedge clock);
    end
    fillValid = 1'b0;
    #1 chk("rstw_pre_en", wayWrEn, 8'h40);
    reset_n = 1'b0;
    #1;
    chk("rstw_en", wayWrEn, 8'h00);
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_ready", fillReady, 1'b1);
    chk("rstw_data", wayWrData, 512'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rstw_idle_en", wayWrEn, 8'h00);
    chk("rstw_idle_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/way_fill_demux.md
Name: way_fill_demux

Overview:
Write-side counterpart to the way-select read multiplexor. It accepts a cache line as a stream of narrow beats from the fill/next-level interface, assembles the full line, and steers it into exactly one of WAYS data arrays. It does this with a one-hot, single-cycle write-enable. It sits between the L2 fill path and the per-way line storage.

Parameters:
lineSize, 512, line width in bits
ways, 8, number of ways (any value ≥2; need not be a power of two)
beatWidth, 64, fill beat width in bits; lineSize must be an integer multiple of it (beats = lineSize/beatWidth)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
fillValid  input  1  beat present on fillData
fillReady  output  1  block can accept a beat this cycle
fillWay  input  $clog2(ways)  destination way; sampled on the first beat only
fillData  input  beatWidth  beat payload
abort  input  1  synchronous discard of any partial line
wayWrEn  output  ways  one-hot write strobe, one bit per way
wayWrData  output  lineSize  assembled line, broadcast to all ways
busy  output  1  line assembly or write in progress
wayError  output  1  one-cycle pulse: completed line targeted a way ≥ ways and was dropped

Behaviour:
- Reset (async assert, sync release) clears all outputs to 0 except fillReady, which is 1:
  - wayWrEn=0, wayWrData=0, busy=0, wayError=0.
  - State goes to IDLE, beat counter to 0.
- A beat transfers on a rising edge with fillValid & fillReady. fillData is don't-care otherwise.
- States:
  - IDLE: fillReady=1, busy=0. On transfer, latch fillWay into wayReg and write the beat into slice 0. beatCnt←1 → COLLECT. If beats==1, go directly to WRITE.
  - COLLECT: fillReady=1, busy=1.
    - On transfer, beat k goes into bits [(k+1)*beatWidth-1 : k*beatWidth]. Beat 0 is the least significant.
    - fillWay is ignored on beats 1..beats-1.
    - On the transfer of beat beats-1 → WRITE.
  - WRITE: fillReady=0, busy=1.
    - Exactly one cycle. wayWrEn[wayReg]=1 if wayReg<ways. Otherwise wayWrEn=0 and wayError=1.
    - wayWrData holds the full line.
    - Next cycle → IDLE with beatCnt=0.
- wayWrData:
  - Is the assembly register itself.
  - Holds its value after WRITE until overwritten by the next line's beats.
  - Is only meaningful while wayWrEn≠0.
- wayWrEn and wayError are registered, high for exactly one cycle per line, never both high.
- Latency: last beat accepted at edge N → wayWrEn high during cycle N..N+1. fillReady back to 1 in the cycle after the write.
- Max throughput: one line per beats+1 cycles.
- abort:
  - In IDLE/COLLECT: discard the partial line, beatCnt←0 → IDLE. A beat presented in the same cycle is not accepted (abort has priority, fillReady forced 0 that cycle).
  - In WRITE: abort is ignored; the write completes.
- fillValid dropping mid-line: wait indefinitely; no timeout.
- Reset mid-line or mid-WRITE: strobe deasserts immediately and the partial line is lost.
- beatCnt width is $clog2(beats)+1 and must not wrap within a line.

Test Plan:
- Reset then idle: hold reset_n=0 3 cycles with fillValid=1 → wayWrEn=0, busy=0, fillReady=1, no beats accepted. Release → IDLE.
- Full line, defaults: fillWay=5, beats 0x0..0x7 (beat k = 64'h1111_1111_1111_1111*k) back-to-back. Required response:
  - wayWrEn=8'b0010_0000 for exactly one cycle, one cycle after the 8th beat.
  - wayWrData[63:0]=0 and wayWrData[511:448]=64'h7777_7777_7777_7777.
  - fillReady=0 that cycle.
- Way latched on first beat: fillWay=2 on beat 0, fillWay=6 on beats 1-7 → only wayWrEn[2] pulses.
- Stalls: same line with fillValid low for 3 cycles between beats 3 and 4 → identical wayWrData. Write occurs one cycle after the last accepted beat.
- Abort: 4 beats to way 1, abort=1 with fillValid=1 → beat not taken, busy=0 next cycle. A fresh 8-beat line to way 3 → only wayWrEn[3] pulses, with no residue from the aborted beats.
- Out-of-range way: ways=6, fillWay=7, full line → wayWrEn=0 throughout, wayError pulses once. The next line to way 0 writes normally.
